// File: rtl/image_row_feeder_if.sv
`timescale 1ns/1ps
// Pixel stream bundle around the row feeder: upstream valid/ready pixels in, framed pixels out.
// Latency: none (wires only).
// Backpressure: s_ready is driven by the feeder, and i_ready by the downstream filter.
interface image_row_feeder_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  s_valid;
    logic [DATA_WIDTH-1:0] s_data;
    logic                  s_ready;
    logic                  i_ready;
    logic                  o_valid;
    logic [DATA_WIDTH-1:0] o_pixel;

    // Feeder side: consumes the raw stream and produces the framed stream.
    modport master (
        input  s_valid, s_data, i_ready,
        output s_ready, o_valid, o_pixel
    );

    // Environment side: pixel source plus downstream filter.
    modport slave (
        output s_valid, s_data, i_ready,
        input  s_ready, o_valid, o_pixel
    );
endinterface

// File: rtl/image_row_feeder.sv
`timescale 1ns/1ps
// image_row_feeder: re-times a raw pixel stream into DEPTH rows of DEPTH pixels, each followed by GAP idle cycles, then PAD_ROWS zero rows.
// Latency: one cycle from an upstream handshake (or a pad beat) to o_valid/o_pixel.
// Backpressure: s_ready follows i_ready only in image rows; pad beats wait for i_ready; the gap counter ignores i_ready.
// Optional feature: define FEEDER_ABORT_EN to add i_abort, which abandons a frame and returns to IDLE without o_frame_done.
module image_row_feeder #(
    parameter  int DATA_WIDTH = 8,
    parameter  int DEPTH      = 512,
    parameter  int GAP        = 512,
    parameter  int PAD_ROWS   = 2,
    localparam int ROW_W      = ((DEPTH + PAD_ROWS) > 1) ? $clog2(DEPTH + PAD_ROWS) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_start,
`ifdef FEEDER_ABORT_EN
    input  logic               i_abort,
`endif
    image_row_feeder_if.master bus,
    output logic [ROW_W-1:0]   o_row_idx,
    output logic               o_busy,
    output logic               o_frame_done
);
    localparam int COL_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int GAP_W   = (GAP > 0) ? $clog2(GAP + 1) : 1;
    localparam bit HAS_GAP = (GAP > 0);

    localparam logic [COL_W-1:0] LAST_COL = COL_W'(DEPTH - 1);
    localparam logic [GAP_W-1:0] LAST_GAP = GAP_W'((GAP > 0) ? (GAP - 1) : 0);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(DEPTH + PAD_ROWS - 1);
    localparam logic [ROW_W-1:0] LAST_IMG = ROW_W'(DEPTH - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ROW  = 3'd1,
        S_GAP  = 3'd2,
        S_PAD  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t                  state_q;
    logic [COL_W-1:0]        col_q;
    logic [ROW_W-1:0]        row_q;
    logic [GAP_W-1:0]        gap_q;
    logic                    o_valid_q;
    logic [DATA_WIDTH-1:0]   o_pixel_q;
    logic                    o_frame_done_q;

    logic                    abort;
    logic                    beat;
    logic                    row_last;
    state_t                  row_next_d;

`ifdef FEEDER_ABORT_EN
    assign abort = i_abort && (state_q != S_IDLE);
`else
    assign abort = 1'b0;
`endif

    // Upstream is only offered a slot while an image row is being sent and the filter can take it.
    assign bus.s_ready = (state_q == S_ROW) && bus.i_ready && !abort;

    // A beat is an image pixel handshake or a zero pixel the filter can accept during a pad row.
    assign beat = !abort &&
                  (((state_q == S_ROW) && bus.s_valid && bus.i_ready) ||
                   ((state_q == S_PAD) && bus.i_ready));

    // Where the frame goes once the current row (and its gap) is finished.
    always_comb begin
        row_last   = (row_q == LAST_ROW);
        row_next_d = S_ROW;
        if (row_last) begin
            row_next_d = S_DONE;
        end else if (row_q >= LAST_IMG) begin
            row_next_d = S_PAD;
        end
    end

    // Frame sequencer: row/column/gap counters plus the registered pixel outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= S_IDLE;
            col_q          <= '0;
            row_q          <= '0;
            gap_q          <= '0;
            o_valid_q      <= 1'b0;
            o_pixel_q      <= '0;
            o_frame_done_q <= 1'b0;
        end else begin
            o_valid_q      <= 1'b0;
            o_frame_done_q <= 1'b0;
            if (abort) begin
                state_q <= S_IDLE;
                col_q   <= '0;
                row_q   <= '0;
                gap_q   <= '0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (i_start) begin
                            state_q <= S_ROW;
                            col_q   <= '0;
                            row_q   <= '0;
                            gap_q   <= '0;
                        end
                    end
                    S_ROW, S_PAD: begin
                        if (beat) begin
                            o_valid_q <= 1'b1;
                            o_pixel_q <= (state_q == S_ROW) ? bus.s_data : '0;
                            if (col_q == LAST_COL) begin
                                col_q <= '0;
                                if (HAS_GAP) begin
                                    state_q <= S_GAP;
                                end else begin
                                    // No gap: the row index advances with the final beat itself.
                                    state_q <= row_next_d;
                                    if (row_last) begin
                                        o_frame_done_q <= 1'b1;
                                    end else begin
                                        row_q <= row_q + ROW_W'(1);
                                    end
                                end
                            end else begin
                                col_q <= col_q + COL_W'(1);
                            end
                        end
                    end
                    S_GAP: begin
                        if (gap_q == LAST_GAP) begin
                            gap_q   <= '0;
                            state_q <= row_next_d;
                            // The last row keeps its index so the counter never wraps inside a frame.
                            if (row_last) begin
                                o_frame_done_q <= 1'b1;
                            end else begin
                                row_q <= row_q + ROW_W'(1);
                            end
                        end else begin
                            gap_q <= gap_q + GAP_W'(1);
                        end
                    end
                    S_DONE: begin
                        state_q <= S_IDLE;
                        row_q   <= '0;
                    end
                    default: begin
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.o_valid   = o_valid_q;
    assign bus.o_pixel   = o_pixel_q;
    assign o_row_idx     = row_q;
    assign o_busy        = (state_q != S_IDLE);
    assign o_frame_done  = o_frame_done_q;

endmodule
